// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the PC register strobes, the instruction-fetch handshake and the
// branch/stall control inputs of pc_fetch_sequencer.
interface pc_fetch_sequencer_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 i_stall;
  logic                 i_redirect;
  logic [WORD_SIZE-1:0] i_target;
  logic                 i_imem_ack;
  logic                 o_pc_cs;
  logic                 o_pc_we;
  logic                 o_pc_oe;
  logic [WORD_SIZE-1:0] o_pc_data;
  logic                 o_imem_req;
  logic [WORD_SIZE-1:0] o_imem_addr;
  logic [WORD_SIZE-1:0] o_pc_value;
  logic                 o_fault;

  modport master (
    input  i_stall,
    input  i_redirect,
    input  i_target,
    input  i_imem_ack,
    output o_pc_cs,
    output o_pc_we,
    output o_pc_oe,
    output o_pc_data,
    output o_imem_req,
    output o_imem_addr,
    output o_pc_value,
    output o_fault
  );

  modport slave (
    output i_stall,
    output i_redirect,
    output i_target,
    output i_imem_ack,
    input  o_pc_cs,
    input  o_pc_we,
    input  o_pc_oe,
    input  o_pc_data,
    input  o_imem_req,
    input  o_imem_addr,
    input  o_pc_value,
    input  o_fault
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Sequences PC register writes and one instruction fetch per PC value,
// advancing sequentially or to a redirect target; sticky fault on ack timeout.
module pc_fetch_sequencer #(
  parameter int unsigned          WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int unsigned          PC_STEP      = 4,
  parameter int unsigned          TIMEOUT      = 15
) (
  input logic                  i_clk,
  input logic                  i_rst,
  pc_fetch_sequencer_if.master bus
);

  localparam logic [WORD_SIZE-1:0] PcStep    = WORD_SIZE'(PC_STEP);
  localparam logic [8:0]           TimeoutLv = 9'(TIMEOUT);

  typedef enum logic [2:0] {
    StBoot,
    StIssue,
    StWait,
    StUpdate,
    StFault
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] tgt_q, tgt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [WORD_SIZE-1:0] next_pc;
  logic                 cs, we, oe, req, fault;
  logic [WORD_SIZE-1:0] pc_data, imem_addr;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    cs        = 1'b0;
    we        = 1'b0;
    oe        = 1'b0;
    req       = 1'b0;
    fault     = 1'b0;
    pc_data   = '0;
    imem_addr = '0;

    // A redirect seen this cycle beats a pending one; pending beats sequential.
    if (bus.i_redirect) begin
      next_pc = bus.i_target;
    end else if (pend_q) begin
      next_pc = tgt_q;
    end else begin
      next_pc = pc_q + PcStep;
    end

    if (bus.i_redirect && (state_q != StFault)) begin
      tgt_d  = bus.i_target;
      pend_d = 1'b1;
    end

    case (state_q)
      StBoot: begin
        cs      = 1'b1;
        we      = 1'b1;
        pc_data = RESET_VECTOR;
        pc_d    = RESET_VECTOR;
        state_d = StIssue;
      end
      StIssue: begin
        cs        = 1'b1;
        oe        = 1'b1;
        req       = 1'b1;
        imem_addr = pc_q;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        cs        = 1'b1;
        oe        = 1'b1;
        req       = 1'b1;
        imem_addr = pc_q;
        cnt_d     = cnt_q + 8'd1;
        // Ack wins over a timeout landing in the same cycle.
        if (bus.i_imem_ack) begin
          state_d = StUpdate;
        end else if (({1'b0, cnt_q} + 9'd1) >= TimeoutLv) begin
          state_d = StFault;
        end
      end
      StUpdate: begin
        cs = 1'b1;
        if (!bus.i_stall) begin
          we      = 1'b1;
          pc_data = next_pc;
          pc_d    = next_pc;
          pend_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StFault: begin
        fault = 1'b1;
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces every output quiet immediately, not just after the edge.
  assign bus.o_pc_cs     = cs & ~i_rst;
  assign bus.o_pc_we     = we & ~i_rst;
  assign bus.o_pc_oe     = oe & ~i_rst;
  assign bus.o_imem_req  = req & ~i_rst;
  assign bus.o_fault     = fault & ~i_rst;
  assign bus.o_pc_data   = i_rst ? '0 : pc_data;
  assign bus.o_imem_addr = i_rst ? '0 : imem_addr;
  assign bus.o_pc_value  = i_rst ? RESET_VECTOR : pc_q;

endmodule
